hazard_unit: RTL
================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5: register-address width.
REQ-002 SHALL have parameter MULTI_LAT, default 4: EX occupancy in cycles of a multi-cycle instruction; legal range 2..15.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port dec_ctrl_i  input  controls_s  decoded control word of the instruction in ID.
REQ-006 SHALL have port dec_valid_i  input  1  ID holds a real instruction.
REQ-007 SHALL have ports dec_rs_i, dec_rt_i  input  REG_ADDR_W  source registers; dec_rs_used_i, dec_rt_used_i  input  1  source actually read.
REQ-008 SHALL have ports dec_rd_i  input  REG_ADDR_W  destination; dec_is_load_i  input  1  instruction is a load.
REQ-009 SHALL have port dec_multi_i  input  1  instruction occupies EX for MULTI_LAT cycles.
REQ-010 SHALL have port branch_taken_i  input  1  branch resolved taken in EX this cycle.
REQ-011 SHALL have port ctrl_o  output  controls_s  control word driven into the newControl input of signal_controller.
REQ-012 SHALL have ports pc_en_o, if_id_en_o  output  1  PC / IF-ID register advance enables.
REQ-013 SHALL have port if_id_flush_o  output  1  clear IF-ID on next edge.
REQ-014 SHALL have port stall_cnt_o  output  16  stall-cycle count.

Function
REQ-015 SHALL define bubble as ctrl_o = all-zero controls_s.
REQ-016 SHALL implement states RUN and MULTI with a 4-bit down-counter mcnt.
REQ-017 Priority per cycle SHALL be: reset > branch flush > MULTI bubble > load-use bubble > issue.
REQ-018 Branch flush (branch_taken_i=1): ctrl_o=bubble, pc_en_o=1, if_id_en_o=1, if_id_flush_o=1; next state RUN, mcnt=0, load shadow cleared; applies in either state.
REQ-019 MULTI: ctrl_o=bubble, pc_en_o=0, if_id_en_o=0; mcnt decrements; at mcnt=1 next state RUN.
REQ-020 Load shadow (ld_v, ld_rd) SHALL be registered each cycle: set to (dec_is_load_i, dec_rd_i) when an instruction issues, else ld_v=0.
REQ-021 Load-use in RUN: ld_v=1, ld_rd!=0, and (dec_rs_used_i & dec_rs_i==ld_rd or dec_rt_used_i & dec_rt_i==ld_rd) with dec_valid_i=1 -> ctrl_o=bubble, pc_en_o=0, if_id_en_o=0, exactly one cycle.
REQ-022 Issue in RUN: ctrl_o=dec_ctrl_i if dec_valid_i else bubble; pc_en_o=1, if_id_en_o=1, if_id_flush_o=0.
REQ-023 Issue with dec_multi_i=1 SHALL enter MULTI with mcnt=MULTI_LAT-1, giving exactly MULTI_LAT-1 bubbles after the issue cycle.
REQ-024 Register 0 SHALL never trigger load-use.
REQ-025 Outputs SHALL be combinational from state and inputs (zero-latency decision); ctrl_o enters pipeline on the same edge.
REQ-026 stall_cnt_o SHALL increment by 1 for each MULTI or load-use bubble cycle, not flush cycles, saturating at 16'hFFFF.

Reset
REQ-027 reset=1 at posedge SHALL force state RUN, mcnt=0, ld_v=0, ld_rd=0, stall_cnt_o=0, including mid-MULTI.
REQ-028 While reset=1 outputs SHALL be ctrl_o=bubble, pc_en_o=0, if_id_en_o=0, if_id_flush_o=1.

Configuration
REQ-029 With HAZARD_PERF_CNT_EN defined, stall counter SHALL be implemented per REQ-026.
REQ-030 Without HAZARD_PERF_CNT_EN, no counter register SHALL exist and stall_cnt_o SHALL be constant 0.

Verification
REQ-031 Load r3 issues, next instruction reads rs=r3 -> one bubble, pc_en_o=0 one cycle, consumer issues cycle after; stall_cnt_o=1.
REQ-032 Load r0 followed by reader of r0 -> no bubble, back-to-back issue.
REQ-033 MULTI_LAT=4, multi instruction issues -> 3 bubble cycles, pc_en_o=0 throughout, stall_cnt_o=3, then RUN.
REQ-034 branch_taken_i=1 during second MULTI bubble -> that cycle if_id_flush_o=1, pc_en_o=1, next cycle RUN issues normally; stall_cnt_o unchanged by flush.
REQ-035 branch_taken_i and load-use same cycle -> flush behaviour only, ld_v=0 next cycle.
REQ-036 reset=1 mid-MULTI, then deasserted -> outputs per REQ-028 during reset, first valid instruction issues on first post-reset cycle, stall_cnt_o=0 (or constant 0 without HAZARD_PERF_CNT_EN).

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use and multi-cycle EX bubbles, taken-branch flush, zero-latency control mux.
// Define HAZARD_PERF_CNT_EN to build the saturating stall-cycle counter; otherwise stall_cnt_o is tied to 0.

package hazard_pkg;
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [3:0] alu_op;
    } controls_s;
endpackage

module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MULTI_LAT  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  controls_s             dec_ctrl_i,
    input  logic                  dec_valid_i,
    input  logic [REG_ADDR_W-1:0] dec_rs_i,
    input  logic [REG_ADDR_W-1:0] dec_rt_i,
    input  logic                  dec_rs_used_i,
    input  logic                  dec_rt_used_i,
    input  logic [REG_ADDR_W-1:0] dec_rd_i,
    input  logic                  dec_is_load_i,
    input  logic                  dec_multi_i,
    input  logic                  branch_taken_i,
    output controls_s             ctrl_o,
    output logic                  pc_en_o,
    output logic                  if_id_en_o,
    output logic                  if_id_flush_o,
    output logic [15:0]           stall_cnt_o
);

    typedef enum logic {RUN, MULTI} state_e;

    localparam logic [3:0] MCNT_INIT = 4'(MULTI_LAT - 1);

    state_e                state_q, state_d;
    logic [3:0]            mcnt_q, mcnt_d;
    logic                  ld_v_q, ld_v_d;
    logic [REG_ADDR_W-1:0] ld_rd_q, ld_rd_d;
    logic                  load_use;
    logic                  issue_vld;

    // Register 0 is hardwired, so a load to it never creates a dependency.
    always_comb begin
        load_use = ld_v_q && (ld_rd_q != '0) && dec_valid_i &&
                   ((dec_rs_used_i && (dec_rs_i == ld_rd_q)) ||
                    (dec_rt_used_i && (dec_rt_i == ld_rd_q)));
    end

    always_comb begin
        ctrl_o        = '0;
        pc_en_o       = 1'b0;
        if_id_en_o    = 1'b0;
        if_id_flush_o = 1'b0;
        issue_vld     = 1'b0;
        if (reset) begin
            if_id_flush_o = 1'b1;
        end else if (branch_taken_i) begin
            pc_en_o       = 1'b1;
            if_id_en_o    = 1'b1;
            if_id_flush_o = 1'b1;
        end else if (state_q == MULTI || load_use) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
        end else begin
            ctrl_o        = dec_valid_i ? dec_ctrl_i : '0;
            pc_en_o       = 1'b1;
            if_id_en_o    = 1'b1;
            issue_vld     = dec_valid_i;
        end
    end

    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        ld_v_d  = 1'b0;
        ld_rd_d = ld_rd_q;
        if (reset) begin
            state_d = RUN;
            mcnt_d  = '0;
            ld_rd_d = '0;
        end else if (branch_taken_i) begin
            state_d = RUN;
            mcnt_d  = '0;
            ld_rd_d = '0;
        end else if (state_q == MULTI) begin
            mcnt_d = mcnt_q - 4'd1;
            if (mcnt_q == 4'd1) begin
                state_d = RUN;
            end
        end else if (issue_vld) begin
            ld_v_d  = dec_is_load_i;
            ld_rd_d = dec_rd_i;
            if (dec_multi_i) begin
                state_d = MULTI;
                mcnt_d  = MCNT_INIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            mcnt_q  <= '0;
            ld_v_q  <= 1'b0;
            ld_rd_q <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
            ld_v_q  <= ld_v_d;
            ld_rd_q <= ld_rd_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall_bubble;

    // Flush cycles are not stalls: the front end still advances.
    always_comb begin
        stall_bubble = !reset && !branch_taken_i && ((state_q == MULTI) || load_use);
        stall_cnt_d  = stall_cnt_q;
        if (stall_bubble && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 16'd0;
`endif

endmodule
